demux_2x4bits_fifo: RTL and testbench

Buffered 1-to-2 nibble demultiplexer. It is the steering counterpart of the 2:1 4-bit selector. A single 4-bit producer stream is routed by SEL into one of two independent per-channel FIFOs. Each FIFO is drained by its own consumer through a valid/ack handshake. The block sits between the shared nibble bus and the two downstream digit consumers, so either consumer can stall without losing data destined for the other.

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_chan_fifo.sv | 54 +++++
 rtl/demux_2x4bits_fifo.sv | 56 +++++
 tb/tb_demux_2x4bits_fifo.sv | 131 +++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared sizing, channel indices and pointer-width helper
// for the buffered 1-to-2 nibble demultiplexer.
package demux_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 2;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: one channel FIFO; head is zeroed when empty so no
// stale entry is ever presented downstream.
module demux_chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PUSH,
    input  logic [WIDTH-1:0] DIN,
    input  logic             POP,
    output logic [WIDTH-1:0] DOUT,
    output logic             EMPTY,
    output logic             FULL
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign EMPTY   = cnt_q == '0;
    assign FULL    = cnt_q == CW'(DEPTH);
    assign do_push = PUSH && !FULL;
    assign do_pop  = POP && !EMPTY;
    assign DOUT    = EMPTY ? '0 : mem_q[rd_q];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= DIN;
        end
    end

endmodule

// File: rtl/demux_2x4bits_fifo.sv
// demux_2x4bits_fifo: steers one nibble stream by SEL into two independent
// channel FIFOs, each drained by its own valid/ack consumer.
module demux_2x4bits_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             SEL,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic [WIDTH-1:0] OUT0,
    output logic             VALID0,
    input  logic             ACK0,
    output logic [WIDTH-1:0] OUT1,
    output logic             VALID1,
    input  logic             ACK1
);

    logic [1:0] full, empty, push, pop;

    // Readiness depends only on registered fullness: no pop bypass.
    assign DIN_READY = !full[SEL];
    assign push[CH0] = DIN_VALID && DIN_READY && (SEL == CH0);
    assign push[CH1] = DIN_VALID && DIN_READY && (SEL == CH1);
    assign VALID0    = !empty[CH0];
    assign VALID1    = !empty[CH1];
    assign pop[CH0]  = ACK0 && VALID0;
    assign pop[CH1]  = ACK1 && VALID1;

    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch0 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .PUSH  (push[CH0]),
        .DIN   (DIN),
        .POP   (pop[CH0]),
        .DOUT  (OUT0),
        .EMPTY (empty[CH0]),
        .FULL  (full[CH0])
    );

    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .PUSH  (push[CH1]),
        .DIN   (DIN),
        .POP   (pop[CH1]),
        .DOUT  (OUT1),
        .EMPTY (empty[CH1]),
        .FULL  (full[CH1])
    );

endmodule

// File: tb/tb_demux_2x4bits_fifo.sv
// tb_demux_2x4bits_fifo: directed stimulus feeding per-channel expected queues;
// a negedge monitor compares VALIDk/OUTk against the queue heads.
module tb_demux_2x4bits_fifo;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] DIN;
    logic       SEL, DIN_VALID, DIN_READY;
    logic [3:0] OUT0, OUT1;
    logic       VALID0, VALID1, ACK0, ACK1;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic       pop0 = 1'b0, pop1 = 1'b0;
    int         passed = 0, total = 0;

    demux_2x4bits_fifo #(.WIDTH(4), .DEPTH(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .SEL(SEL), .DIN_VALID(DIN_VALID),
        .DIN_READY(DIN_READY), .OUT0(OUT0), .VALID0(VALID0), .ACK0(ACK0),
        .OUT1(OUT1), .VALID1(VALID1), .ACK1(ACK1)
    );

    always #5 CLK = ~CLK;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    always @(negedge CLK) begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (RST_N) begin
            check("valid0", VALID0, q0.size() != 0);
            check("out0", OUT0, q0.size() != 0 ? q0[0] : 4'h0);
            check("valid1", VALID1, q1.size() != 0);
            check("out1", OUT1, q1.size() != 0 ? q1[0] : 4'h0);
            pop0 = ACK0 && q0.size() != 0;
            pop1 = ACK1 && q1.size() != 0;
        end
    end

    always @(posedge CLK) begin
        if (pop0) q0.delete(0);
        if (pop1) q1.delete(0);
    end

    // One clock of stimulus; exp_rdy is the hand-derived DIN_READY for this cycle.
    task automatic cyc(input logic v, input logic s, input logic [3:0] d,
                       input logic a0, input logic a1, input logic exp_rdy);
        DIN_VALID = v; SEL = s; DIN = d; ACK0 = a0; ACK1 = a1;
        @(negedge CLK);
        if (v) check("din_ready", DIN_READY, exp_rdy);
        @(posedge CLK);
        if (v && exp_rdy) begin
            if (s) q1.push_back(d);
            else q0.push_back(d);
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; DIN = 4'h0; SEL = 1'b0; DIN_VALID = 1'b0; ACK0 = 1'b0; ACK1 = 1'b0;
        @(negedge CLK);
        check("rst_valid0", VALID0, 1'b0);
        check("rst_valid1", VALID1, 1'b0);
        check("rst_out0", OUT0, 4'h0);
        check("rst_out1", OUT1, 4'h0);
        check("rst_ready", DIN_READY, 1'b1);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        // single pushes into each channel
        cyc(1, 0, 4'h5, 0, 0, 1);
        cyc(1, 1, 4'hA, 0, 0, 1);
        cyc(0, 0, 4'h0, 1, 1, 0);
        // fill channel 0, hold 9 while refused, pop once (no bypass), then accept
        cyc(1, 0, 4'h3, 0, 0, 1);
        cyc(1, 0, 4'h7, 0, 0, 1);
        cyc(1, 0, 4'h9, 0, 0, 0);
        cyc(1, 0, 4'h9, 0, 0, 0);
        cyc(1, 0, 4'h9, 1, 0, 0);
        cyc(1, 0, 4'h9, 0, 0, 1);
        // channel 0 full, channel 1 still accepts
        cyc(1, 0, 4'hB, 0, 0, 0);
        cyc(1, 1, 4'hC, 0, 0, 1);
        // simultaneous push and pop on channel 1
        cyc(1, 1, 4'h2, 0, 1, 1);
        cyc(1, 1, 4'hE, 0, 1, 1);
        cyc(0, 1, 4'h0, 0, 1, 0);
        cyc(0, 0, 4'h0, 1, 1, 0);
        cyc(0, 0, 4'h0, 1, 1, 0);
        // ack on empty channels must be ignored
        cyc(0, 0, 4'h0, 1, 1, 0);
        // pointer wrap through channel 0
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 4'(i), 0, 0, 1);
            cyc(0, 0, 4'h0, 1, 0, 0);
        end
        // back-to-back fill of both channels, then async reset between edges
        cyc(1, 0, 4'h6, 0, 0, 1);
        cyc(1, 1, 4'h8, 0, 0, 1);
        cyc(1, 1, 4'h4, 0, 0, 1);
        cyc(0, 0, 4'h0, 0, 0, 0);
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_valid0", VALID0, 1'b0);
        check("mid_rst_valid1", VALID1, 1'b0);
        check("mid_rst_out0", OUT0, 4'h0);
        check("mid_rst_out1", OUT1, 4'h0);
        SEL = 1'b1;
        #1 check("mid_rst_ready", DIN_READY, 1'b1);
        q0.delete();
        q1.delete();
        @(posedge CLK);
        #1 RST_N = 1'b1;
        cyc(1, 0, 4'h1, 0, 0, 1);
        cyc(0, 0, 4'h0, 0, 0, 0);
        cyc(0, 0, 4'h0, 1, 0, 0);
        cyc(0, 0, 4'h0, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
